// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: data width and the
// transmit-buffer launch FSM encoding.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } tx_fifo_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular-buffer FIFO with a separate occupancy counter.
// Full/empty are decoded from the registered count; overflow is a registered pulse.
module uart_sync_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int WIDTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_Wr_En,
  input  logic [WIDTH-1:0]  i_Wr_Data,
  input  logic              i_Rd_En,
  output logic [WIDTH-1:0]  o_Rd_Data,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Full,
  output logic              o_Empty,
  output logic              o_Overflow
);

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              wr_acc;
  logic              rd_acc;

  assign o_Full     = (count_q == CNT_FULL);
  assign o_Empty    = (count_q == '0);
  assign o_Count    = count_q;
  assign o_Overflow = overflow_q;
  assign o_Rd_Data  = mem_q[rd_ptr_q];

  // A full FIFO rejects the write even when a pop frees a slot in the same cycle.
  assign wr_acc = i_Wr_En & ~o_Full;
  assign rd_acc = i_Rd_En & ~o_Empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = i_Wr_En & o_Full;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CNT_ONE;
    end else if (!wr_acc && rd_acc) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset_n && wr_acc) mem_q[wr_ptr_q] <= i_Wr_Data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of uart_tx: queues host writes and launches them one
// at a time over the uart_tx DV/byte handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic                   i_Wr_DV,
  input  logic [UART_DATA_W-1:0] i_Wr_Byte,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [ADDR_W:0]        o_Count,
  output logic                   o_Overflow,
  output logic                   o_Busy,
  output logic                   o_Tx_DV,
  output logic [UART_DATA_W-1:0] o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done,
  output tx_fifo_state_t         o_State
);

  // Handshake: o_Tx_DV is a single-cycle launch strobe; o_Tx_Byte is stable
  // from that strobe until the next one, and a new strobe is issued only
  // after uart_tx has reported Done and then dropped both Done and Active.

  tx_fifo_state_t         state_q;
  logic                   tx_dv_q;
  logic [UART_DATA_W-1:0] tx_byte_q;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   fifo_empty;
  logic                   pop;

  assign pop = (state_q == IDLE) && !fifo_empty;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .i_Clock    (i_Clock),
    .i_Reset_n  (i_Reset_n),
    .i_Wr_En    (i_Wr_DV),
    .i_Wr_Data  (i_Wr_Byte),
    .i_Rd_En    (pop),
    .o_Rd_Data  (rd_data),
    .o_Count    (o_Count),
    .o_Full     (o_Full),
    .o_Empty    (fifo_empty),
    .o_Overflow (o_Overflow)
  );

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q   <= IDLE;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      tx_dv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q   <= LAUNCH;
            tx_dv_q   <= 1'b1;
            tx_byte_q <= rd_data;
          end
        end
        LAUNCH:    state_q <= WAIT_DONE;
        WAIT_DONE: if (i_Tx_Done) state_q <= GAP;
        // Done may stay high for more than one cycle; wait for it to clear.
        GAP:       if (!i_Tx_Done && !i_Tx_Active) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign o_Empty   = fifo_empty;
  assign o_Busy    = (state_q != IDLE);
  assign o_Tx_DV   = tx_dv_q;
  assign o_Tx_Byte = tx_byte_q;
  assign o_State   = state_q;

endmodule
